// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bit-position counter width; never narrower than one bit.
  function automatic int count_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder; port shape mirrors the subtractor bit cell.
module full_adder (
  output logic s,
  output logic cout,
  input  logic x,
  input  logic y,
  input  logic cin
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands captured on start, summed LSB-first
// through one full adder and a carry flop, result flagged by a done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = count_width(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             carry;
  logic [CW-1:0]    count;
  logic             bit_s, bit_c;
  logic             last;

  full_adder u_fa (
    .s    (bit_s),
    .cout (bit_c),
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry)
  );

  assign last = (count == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_SHIFT;
      S_SHIFT: if (last)  state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // The final bit is merged straight into sum so the result lands on the
  // same edge that leaves SHIFT, rather than one edge later via res.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            res   <= '0;
            carry <= cin;
            count <= '0;
          end
        end
        S_SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= {bit_s, res[WIDTH-1:1]};
          carry <= bit_c;
          count <= count + CW'(1);
          if (last) begin
            sum  <= {bit_s, res[WIDTH-1:1]};
            cout <= bit_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver predicts acceptance and result
// timing from the protocol rules, a negedge monitor compares every cycle.
module tb_serial_adder;

  localparam int W = 4;

  typedef struct {
    logic [W:0]   val;
    int           cyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset, start, cin;
  logic [W-1:0] a, b, sum;
  logic         cout, busy, done;

  always #5 clock = ~clock;

  serial_adder #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         rst_edge = -1;
  int         free_edge = 0;
  int         busy_lo = 1;
  int         busy_hi = 0;
  logic [W:0] held_exp = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: sample outputs on the falling edge, after edge number cyc.
  always @(negedge clock) begin
    logic         exp_done;
    exp_t         cur;
    logic [W-1:0] diff;
    if (cyc >= 1) begin
      exp_done = 1'b0;
      if (cyc == rst_edge) held_exp = '0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_done = 1'b1;
        cur      = q.pop_front();
        held_exp = cur.val;
        diff     = sum - cur.b - W'(cur.ci);
        chk("roundtrip", int'(diff), int'(cur.a));
      end
      chk("done", int'(done), int'(exp_done));
      chk("sum",  int'(sum),  int'(held_exp[W-1:0]));
      chk("cout", int'(cout), int'(held_exp[W]));
      chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  // Drive one edge (e = cyc+1) and update the protocol model for it.
  task automatic step(input logic r, input logic s, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic c, output bit acc);
    int   e;
    exp_t x;
    e     = cyc + 1;
    reset = r;
    start = s;
    a     = av;
    b     = bv;
    cin   = c;
    acc   = 1'b0;
    if (r) begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].cyc >= e) q.delete(i);
      rst_edge  = e;
      free_edge = e + 1;
      if (busy_hi >= e) busy_hi = e - 1;
    end else if (s && e >= free_edge) begin
      x.val = {1'b0, av} + {1'b0, bv} + (W+1)'(c);
      x.cyc = e + W;
      x.a   = av;
      x.b   = bv;
      x.ci  = c;
      q.push_back(x);
      busy_lo   = e;
      busy_hi   = e + W;
      free_edge = e + W + 2;
      acc       = 1'b1;
    end
    @(negedge clock);
    #1;
  endtask

  // Hold start until accepted; operands are scrambled on edges that cannot accept.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < W + 4 && !acc; i++) begin
      if (cyc + 1 >= free_edge) step(1'b0, 1'b1, av, bv, c, acc);
      else step(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), acc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    @(negedge clock);
    #1;
    step(1'b1, 1'b1, 4'd3, 4'd3, 1'b0, acc);
    step(1'b1, 1'b0, '0, '0, 1'b0, acc);

    run_op(4'd5, 4'd3, 1'b0);
    run_op(4'd15, 4'd1, 1'b0);
    run_op(4'd15, 4'd15, 1'b1);
    for (int i = 0; i < 4; i++) run_op(4'd2, 4'd2, 1'b0);

    // Reset on the second SHIFT edge, then a clean operation.
    run_op(4'd2, 4'd2, 1'b0);
    step(1'b0, 1'b0, 4'd1, 4'd1, 1'b0, acc);
    step(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, acc);
    run_op(4'd7, 4'd9, 1'b0);

    // Start during DONE is dropped; the following IDLE cycle accepts.
    run_op(4'd5, 4'd6, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, 1'b0, W'($urandom), W'($urandom), 1'b1, acc);
    step(1'b0, 1'b1, 4'd1, 4'd1, 1'b0, acc);
    step(1'b0, 1'b1, 4'd3, 4'd4, 1'b0, acc);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 49) == 0), 1'($urandom), W'($urandom),
           W'($urandom), 1'($urandom), acc);

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          run_op(W'(ai), W'(bi), 1'(ci));

    for (int i = 0; i < 3 * W && q.size() > 0; i++)
      step(1'b0, 1'b0, '0, '0, 1'b0, acc);
    chk("drain", q.size(), 0);
    step(1'b0, 1'b0, '0, '0, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
